// File: rtl/button_pkg.sv
// Shared types and constants for the button gesture decoder.
// Holds the FSM state encoding, default ms timings and the timer width helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    HOLD,
    WAIT2,
    PRESSED2
  } state_e;

  localparam int unsigned DEF_CLK_PER_MS = 50000;
  localparam int unsigned DEF_LONG_MS    = 1000;
  localparam int unsigned DEF_DOUBLE_MS  = 300;
  localparam int unsigned DEF_REPEAT_MS  = 200;

  // Bits needed to hold the largest ms threshold.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_ms_tick.sv
// Millisecond prescaler: TICK is high for the last cycle of every ms period.
// CLR restarts the period so ms timing is measured from a button edge.
module button_ms_tick #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (CLR || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign TICK = (cnt_q == LAST) && !CLR;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle gesture pulses:
// press/release, click, double-click, long press and auto-repeat.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = DEF_CLK_PER_MS,
  parameter int unsigned LONG_MS    = DEF_LONG_MS,
  parameter int unsigned DOUBLE_MS  = DEF_DOUBLE_MS,
  parameter int unsigned REPEAT_MS  = DEF_REPEAT_MS,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic PRESS,
  output logic RELEASE,
  output logic CLICK,
  output logic DCLICK,
  output logic LONG,
  output logic REPEAT,
  output logic HELD
);

  localparam int unsigned TW = timer_width(LONG_MS, DOUBLE_MS, REPEAT_MS);
  localparam logic [TW-1:0] T_LONG = TW'(LONG_MS);
  localparam logic [TW-1:0] T_DBL  = TW'(DOUBLE_MS);
  localparam logic [TW-1:0] T_REP  = TW'(REPEAT_MS);
  localparam logic [TW-1:0] T_MAX  = '1;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          in_q, prev_q;
  logic          press_q, release_q, held_q;
  logic          click_q, click_d;
  logic          dclick_q, dclick_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          press_c, release_c, tick;

  assign press_c   = in_q & ~prev_q;
  assign release_c = ~in_q & prev_q;

  button_ms_tick #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .CLR (press_c | release_c),
    .TICK(tick)
  );

  // Gesture FSM; an edge always beats a timer expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (tick && (timer_q != T_MAX)) timer_d = timer_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (press_c) state_d = PRESSED;
      end
      PRESSED: begin
        if (release_c) begin
          if (DOUBLE_MS == 0) begin
            click_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT2;
          end
        end else if (timer_q == T_LONG) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (release_c) begin
          state_d = IDLE;
        end else if (timer_q == T_REP) begin
          repeat_d = 1'b1;
          timer_d  = '0;
        end
      end
      WAIT2: begin
        if (press_c) begin
          state_d = PRESSED2;
        end else if (timer_q == T_DBL) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESSED2: begin
        if (release_c) begin
          dclick_d = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == T_LONG) begin
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      in_q      <= 1'b0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      in_q      <= IN ^ ACTIVE_LOW;
      prev_q    <= in_q;
      press_q   <= press_c;
      release_q <= release_c;
      held_q    <= in_q;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign CLICK   = click_q;
  assign DCLICK  = dclick_q;
  assign LONG    = long_q;
  assign REPEAT  = repeat_q;
  assign HELD    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: a ms-level gesture model checked every cycle
// against two instances (double-click window 5 ms and disabled), plus literal timings.
module tb_button_event_decoder;

  localparam int TB_N = 10;
  localparam int TB_L = 20;
  localparam int TB_D = 5;
  localparam int TB_R = 4;

  localparam int PH_IDLE     = 0;
  localparam int PH_PRESSED  = 1;
  localparam int PH_HOLD     = 2;
  localparam int PH_WAIT2    = 3;
  localparam int PH_PRESSED2 = 4;

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic lng;
    logic rep;
    logic held;
  } ev_t;

  // Model state: pipelined level, gesture phase, cycles since the last edge,
  // and the ms count at which the current timed phase started.
  typedef struct {
    logic inq;
    logic prev;
    int   phase;
    int   a;
    int   base;
    ev_t  o;
  } mst_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IN  = 1'b1;

  logic press_a, rel_a, click_a, dclick_a, long_a, rep_a, held_a;
  logic press_b, rel_b, click_b, dclick_b, long_b, rep_b, held_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  mst_t ma, mb;
  ev_t  last_a, last_b;

  int q_press[$], q_rel[$], q_click[$], q_dclick[$], q_long[$], q_rep[$], q_click_b[$];
  int b_press, b_rel, b_click, b_dclick, b_long, b_rep, b_click_b;

  button_event_decoder #(
    .CLK_PER_MS(TB_N), .LONG_MS(TB_L), .DOUBLE_MS(TB_D), .REPEAT_MS(TB_R), .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .IN(IN),
    .PRESS(press_a), .RELEASE(rel_a), .CLICK(click_a), .DCLICK(dclick_a),
    .LONG(long_a), .REPEAT(rep_a), .HELD(held_a)
  );

  button_event_decoder #(
    .CLK_PER_MS(TB_N), .LONG_MS(TB_L), .DOUBLE_MS(0), .REPEAT_MS(TB_R), .ACTIVE_LOW(1'b1)
  ) dut_nd (
    .CLK(CLK), .RST(RST), .IN(IN),
    .PRESS(press_b), .RELEASE(rel_b), .CLICK(click_b), .DCLICK(dclick_b),
    .LONG(long_b), .REPEAT(rep_b), .HELD(held_b)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic mst_t model_step(input mst_t m, input logic lvl, input logic rst,
                                      input int dbl);
    mst_t n;
    int   ms;
    int   t;
    logic pe;
    logic re;
    n   = m;
    n.o = '0;
    if (rst) begin
      n.inq = 1'b0; n.prev = 1'b0; n.phase = PH_IDLE; n.a = 0; n.base = 0;
      return n;
    end
    pe = m.inq & ~m.prev;
    re = ~m.inq & m.prev;
    ms = m.a / TB_N;
    t  = ms - m.base;
    n.o.press = pe;
    n.o.rel   = re;
    n.o.held  = m.inq;
    case (m.phase)
      PH_IDLE: if (pe) n.phase = PH_PRESSED;
      PH_PRESSED: begin
        if (re) begin
          if (dbl == 0) begin n.o.click = 1'b1; n.phase = PH_IDLE; end
          else n.phase = PH_WAIT2;
        end else if (t == TB_L) begin
          n.o.lng = 1'b1; n.phase = PH_HOLD; n.base = ms;
        end
      end
      PH_HOLD: begin
        if (re) n.phase = PH_IDLE;
        else if (t == TB_R) begin n.o.rep = 1'b1; n.base = ms; end
      end
      PH_WAIT2: begin
        if (pe) n.phase = PH_PRESSED2;
        else if (t == dbl) begin n.o.click = 1'b1; n.phase = PH_IDLE; end
      end
      default: begin
        if (re) begin n.o.dclick = 1'b1; n.phase = PH_IDLE; end
        else if (t == TB_L) begin
          n.o.click = 1'b1; n.o.lng = 1'b1; n.phase = PH_HOLD; n.base = ms;
        end
      end
    endcase
    if (pe || re) begin n.a = 0; n.base = 0; end
    else n.a = m.a + 1;
    n.prev = m.inq;
    n.inq  = ~lvl;
    return n;
  endfunction

  always @(posedge CLK) begin
    ma <= model_step(ma, IN, RST, TB_D);
    mb <= model_step(mb, IN, RST, 0);
  end

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string name, input ev_t got, input ev_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b (press,rel,click,dclick,long,rep,held)",
               name, cyc, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, check both instances, log pulses.
  task automatic step_cycle();
    @(negedge CLK);
    last_a = {press_a, rel_a, click_a, dclick_a, long_a, rep_a, held_a};
    last_b = {press_b, rel_b, click_b, dclick_b, long_b, rep_b, held_b};
    cmp("cycle_dut", last_a, ma.o);
    cmp("cycle_dut_nd", last_b, mb.o);
    if (last_a.press)  q_press.push_back(cyc);
    if (last_a.rel)    q_rel.push_back(cyc);
    if (last_a.click)  q_click.push_back(cyc);
    if (last_a.dclick) q_dclick.push_back(cyc);
    if (last_a.lng)    q_long.push_back(cyc);
    if (last_a.rep)    q_rep.push_back(cyc);
    if (last_b.click)  q_click_b.push_back(cyc);
  endtask

  task automatic hold(input logic v, input int n, output int t_drv);
    IN    = v;
    t_drv = cyc;
    repeat (n) step_cycle();
  endtask

  task automatic snap();
    b_press = q_press.size(); b_rel = q_rel.size(); b_click = q_click.size();
    b_dclick = q_dclick.size(); b_long = q_long.size(); b_rep = q_rep.size();
    b_click_b = q_click_b.size();
  endtask

  initial begin
    int tf, tr, tr1, tr2, td;

    repeat (3) step_cycle();
    chk("reset_outputs", int'(last_a), 0);
    RST = 1'b0;
    hold(1'b1, 20, tr);

    // Short click
    snap();
    hold(1'b0, 80, tf);
    hold(1'b1, 80, tr);
    chk("click.n_press", q_press.size() - b_press, 1);
    chk("click.press_lat", at(q_press, b_press) - tf, 2);
    chk("click.release_lat", at(q_rel, b_rel) - tr, 2);
    chk("click.n_click", q_click.size() - b_click, 1);
    chk("click.click_after_release", at(q_click, b_click) - at(q_rel, b_rel), 51);
    chk("click.n_long", q_long.size() - b_long, 0);
    chk("click.n_dclick", q_dclick.size() - b_dclick, 0);
    chk("click_nd.n_click", q_click_b.size() - b_click_b, 1);
    chk("click_nd.click_lat", at(q_click_b, b_click_b) - tr, 2);

    // Double click
    snap();
    hold(1'b0, 30, tf);
    hold(1'b1, 20, tr1);
    hold(1'b0, 30, tf);
    hold(1'b1, 80, tr2);
    chk("dclick.n_dclick", q_dclick.size() - b_dclick, 1);
    chk("dclick.lat", at(q_dclick, b_dclick) - tr2, 2);
    chk("dclick.n_click", q_click.size() - b_click, 0);
    chk("dclick_nd.n_click", q_click_b.size() - b_click_b, 2);

    // Long press with auto-repeat
    snap();
    hold(1'b0, 400, tf);
    hold(1'b1, 80, tr);
    chk("long.n_long", q_long.size() - b_long, 1);
    chk("long.after_press", at(q_long, b_long) - at(q_press, b_press), 201);
    chk("long.n_repeat", q_rep.size() - b_rep, 4);
    chk("long.rep1_after_press", at(q_rep, b_rep) - at(q_press, b_press), 241);
    chk("long.rep4_after_press", at(q_rep, b_rep + 3) - at(q_press, b_press), 361);
    chk("long.n_click", q_click.size() - b_click, 0);
    chk("long.release_lat", at(q_rel, b_rel) - tr, 2);

    // Double-click window expires between presses
    snap();
    hold(1'b0, 30, tf);
    hold(1'b1, 60, tr1);
    hold(1'b0, 30, tf);
    hold(1'b1, 80, tr2);
    chk("expire.n_click", q_click.size() - b_click, 2);
    chk("expire.click1", at(q_click, b_click) - tr1, 53);
    chk("expire.click2", at(q_click, b_click + 1) - tr2, 53);
    chk("expire.n_dclick", q_dclick.size() - b_dclick, 0);

    // Release lands on the cycle the timer reaches the long threshold
    snap();
    hold(1'b0, 201, tf);
    hold(1'b1, 80, tr);
    chk("edge_long.n_long", q_long.size() - b_long, 0);
    chk("edge_long.click_lat", at(q_click, b_click) - tr, 53);

    // One cycle later the long press wins instead
    snap();
    hold(1'b0, 202, tf);
    hold(1'b1, 80, tr);
    chk("late_rel.n_long", q_long.size() - b_long, 1);
    chk("late_rel.n_click", q_click.size() - b_click, 0);

    // Reset during the double-click window
    snap();
    hold(1'b0, 30, tf);
    hold(1'b1, 10, tr);
    RST = 1'b1;
    hold(1'b1, 1, tr);
    chk("rst.outputs_dut", int'(last_a), 0);
    chk("rst.outputs_dut_nd", int'(last_b), 0);
    hold(1'b1, 2, tr);
    RST = 1'b0;
    hold(1'b1, 100, tr);
    chk("rst.n_click", q_click.size() - b_click, 0);

    // Button held while reset deasserts
    RST = 1'b1;
    hold(1'b0, 3, tf);
    snap();
    RST = 1'b0;
    hold(1'b0, 10, td);
    hold(1'b1, 80, tr);
    chk("rst_held.press_lat", at(q_press, b_press) - td, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the clean, debounced button level from `button` into single-cycle user events: press, release, click, double-click, long press and auto-repeat. It sits directly downstream of `button.OUT`, in the same 50 MHz `CLK` domain, and feeds control logic that needs gestures rather than raw levels. All timing is in milliseconds, derived from an internal prescaler.

## Interface
- `CLK_PER_MS`, 50000: `CLK` cycles per millisecond tick.
- `LONG_MS`, 1000: hold time that qualifies as a long press.
- `DOUBLE_MS`, 300: window after a release in which a second press counts as a double-click. 0 disables double-click.
- `REPEAT_MS`, 200: auto-repeat period while a long press is held.
- `ACTIVE_LOW`, 1: when 1, `IN`=0 means pressed. The button idles high.

- `CLK` in 1: single clock. Reset is synchronous and active-high.
- `RST` in 1: synchronous, active-high reset.
- `IN` in 1: debounced button level, synchronous to `CLK`.
- `PRESS` out 1: one-cycle pulse on the press edge.
- `RELEASE` out 1: one-cycle pulse on the release edge.
- `CLICK` out 1: one-cycle pulse for a short single press.
- `DCLICK` out 1: one-cycle pulse for a completed double-click.
- `LONG` out 1: one-cycle pulse when a hold reaches `LONG_MS`.
- `REPEAT` out 1: one-cycle pulse every `REPEAT_MS` after `LONG`.
- `HELD` out 1: registered level, 1 while the button is pressed.

## Operation
- Normalisation: `act = IN ^ ACTIVE_LOW`.
- Edge detection:
  - `in_q <= act`, `prev <= in_q`.
  - Press edge: `in_q & ~prev`. Release edge: `~in_q & prev`.
- Prescaler:
  - Counts 0..`CLK_PER_MS`-1 and emits a `tick` on wrap.
  - Reloads to 0 on any edge, so ms timing is measured from the edge.
- Timer:
  - Width is `$clog2(max(LONG_MS, DOUBLE_MS, REPEAT_MS)+1)`.
  - Increments on `tick` and saturates at its maximum value.
  - Cleared on every state transition and on every `REPEAT` pulse.
- FSM transitions:
  - IDLE: press → PRESSED.
  - PRESSED:
    - Release → WAIT2. If `DOUBLE_MS`=0, release instead emits `CLICK` and goes → IDLE.
    - timer==`LONG_MS` → `LONG`, → HOLD.
  - HOLD:
    - timer==`REPEAT_MS` → `REPEAT`, then clear the timer.
    - Release → IDLE. No `CLICK` is emitted.
  - WAIT2:
    - Press → PRESSED2.
    - timer==`DOUBLE_MS` → `CLICK`, → IDLE.
  - PRESSED2:
    - Release → `DCLICK`, → IDLE.
    - timer==`LONG_MS` → `CLICK` and `LONG` in the same cycle, → HOLD.
- `PRESS` and `RELEASE` fire on every edge, in every state, independent of the FSM.
- Priority: an edge in the same cycle as a timer expiry wins. The expiry event is not emitted.
- Outputs are mutually exclusive except:
  - `PRESS`/`RELEASE` may coincide with FSM events.
  - `CLICK` and `LONG` coincide in PRESSED2.

## Timing
- Reset state:
  - FSM is IDLE; timer and prescaler are 0.
  - `in_q` and `prev` are loaded with the inactive value (0 after normalisation).
  - All outputs are 0.
- If the button is held while `RST` deasserts, `PRESS` fires 2 cycles later and the FSM enters PRESSED. This is intended.
- Latency: `IN` changes before edge k → `in_q` updates at k → `PRESS`/`RELEASE` and FSM edge events are registered at edge k+1. `HELD` follows `in_q` at edge k+1.
- Timer-event latency: `LONG` is asserted `LONG_MS*CLK_PER_MS` cycles after `PRESS`, ±1 cycle, and never earlier.
- `RST` asserted mid-gesture aborts the gesture. No pending `CLICK` is emitted.

## Structure
- Package `button_pkg`:
  - FSM state enum (IDLE, PRESSED, HOLD, WAIT2, PRESSED2).
  - Default timing constants.
  - Width helper function.
- Sub-module `button_ms_tick`: parameter `CLK_PER_MS`; ports `CLK`, `RST`, `CLR`, `TICK`.
- Top level: edge detector, FSM, timer and output registers.

## Test plan
Use `CLK_PER_MS`=10, `LONG_MS`=20, `DOUBLE_MS`=5, `REPEAT_MS`=4. `IN` idles 1.
- Click: `IN`=0 for 80 cycles, then 1 → `PRESS` 2 cycles after the fall, `RELEASE` 2 cycles after the rise, `CLICK` ~50 cycles after the release. No `LONG` or `DCLICK`.
- Double-click: press 30 cycles, gap 20 cycles, press 30 cycles → exactly one `DCLICK` at the second release +2 cycles. No `CLICK`.
- Long press with repeat: hold 400 cycles → `LONG` at ~200 cycles, `REPEAT` at ~240/280/320/360. No `CLICK` on release. `HELD`=1 throughout the hold.
- Window expiry: press 30 cycles, gap 60 cycles, press 30 cycles → two `CLICK` pulses, no `DCLICK`.
- Reset mid-gesture: assert `RST` during WAIT2 → no `CLICK`, all outputs 0 for the cycle after reset. Holding `IN`=0 through the `RST` deassertion → `PRESS` 2 cycles later.
- Boundary case:
  - Release arrives in the same cycle the timer equals `LONG_MS` → no `LONG`, goes to WAIT2.
  - With `DOUBLE_MS`=0, a short press → `CLICK` 2 cycles after the release.
